run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: instruction/register word width in bits.
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 4 (power of 2): words per main-memory block.
REQ-003 SHALL have parameter N_BLOCKS, default 64 (power of 2): number of main-memory blocks.
REQ-004 SHALL have parameter N_REGS, default 32: number of ARF entries dumped.
REQ-005 SHALL have parameter HALT_PC, default 0: PC value that ends a run.
REQ-006 SHALL have parameter TIMEOUT, default 1000: RUN cycles before forced stop.
REQ-007 SHALL have parameter INIT_CYCLES, default 1: length of core_init pulse in cycles.
REQ-008 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load/run/dump sequence.
- load_base_addr  in  32  byte address of the first program word, word-aligned.
- load_valid / load_ready  in / out  1 / 1  program word handshake.
- load_word  in  WORD_WIDTH  program word.
- load_last  in  1  marks the final program word.
- mem_wr_en  out  1  block write strobe.
- mem_wr_block_addr  out  log2(N_BLOCKS)  block index.
- mem_wr_data  out  WORD_WIDTH*WORDS_PER_BLOCK  block data, lane i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- mem_wr_wmask  out  WORDS_PER_BLOCK  per-word write enables.
- core_init  out  1  core initialisation pulse.
- core_pc  in  32  current core fetch PC.
- arf_in  in  N_REGS*WORD_WIDTH  flattened ARF contents.
- dump_valid / dump_ready  out / in  1 / 1  register dump handshake.
- dump_idx  out  log2(N_REGS)  register index.
- dump_data  out  WORD_WIDTH  register value.
- done  out  1  sequence complete.
- timed_out  out  1  run ended by timeout.
- load_oob  out  1  a word addressed past the last block was dropped.
- cycle_count  out  32  RUN cycles elapsed.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, INIT, RUN, DUMP, DONE.
REQ-010 SHALL, in IDLE or DONE, on start: latch word pointer = load_base_addr>>2; clear done, timed_out, load_oob, cycle_count; enter LOAD. start SHALL be ignored in all other states.
REQ-011 SHALL hold load_ready=1 only in LOAD; a word is accepted when load_valid && load_ready.
REQ-012 SHALL place each accepted word in the block buffer at lane = pointer mod WORDS_PER_BLOCK, set that mask bit, and increment the pointer.
REQ-013 SHALL flush when the accepted word fills lane WORDS_PER_BLOCK-1 or has load_last=1: on the next edge, mem_wr_en=1 for exactly one cycle, with block addr = pointer/WORDS_PER_BLOCK, data and mask including that word; buffer and mask clear on the same edge.
REQ-014 SHALL allow back-to-back word acceptance across a flush (no bubble).
REQ-015 SHALL drop any word whose block index is >= N_BLOCKS (no write, no wrap) and set load_oob sticky.
REQ-016 SHALL go LOAD -> INIT on acceptance of load_last, asserting core_init for exactly INIT_CYCLES cycles starting the cycle after the final flush write.
REQ-017 SHALL go INIT -> RUN after the pulse; in RUN, cycle_count increments each cycle, saturating at 2^32-1.
REQ-018 SHALL compare core_pc with HALT_PC only in RUN; on equality, go to DUMP with timed_out=0.
REQ-019 SHALL go to DUMP with timed_out=1 when cycle_count reaches TIMEOUT without a halt; if both occur in the same cycle, halt wins (timed_out=0).
REQ-020 SHALL snapshot arf_in on entry to DUMP and present entries in index order 0..N_REGS-1, with dump_valid held and dump_idx/dump_data stable until dump_ready.
REQ-021 SHALL go to DONE after the handshake on index N_REGS-1, holding done=1 until the next start.

Reset
REQ-022 SHALL, on rst at any time (including mid-LOAD/RUN/DUMP), enter IDLE immediately, clear the block buffer, pointer and counters, and drive every output to 0.

Verification
REQ-023 With base 0x18c, 14 words 0x100..0x10D, last on the 14th: writes blk 0x18 mask 1000, blk 0x19/0x1a/0x1b mask 1111, blk 0x1c mask 0001 holding 0x10D; then core_init high for 1 cycle.
REQ-024 With core_pc=0x1018c for 37 RUN cycles, then 0x0: timed_out=0, cycle_count=38, 32 dump beats in order 0..31 matching the arf_in snapshot.
REQ-025 With core_pc never 0: after 1000 RUN cycles, timed_out=1, then a full dump, then done=1.
REQ-026 With base 0x3FC and 2 words: word 1 written to blk 0x3F lane 3, word 2 dropped, load_oob=1, one write only.
REQ-027 With dump_ready toggling 1-of-3 cycles: each index is held stable until its handshake, and no index is skipped or repeated.
REQ-028 With rst asserted mid-RUN: all outputs 0 at once; a later start with the same program reproduces REQ-023.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: loads a program into block memory, pulses core init, runs the core until
// its PC reaches HALT_PC or TIMEOUT run cycles elapse, then streams the ARF out.
// Latency: a block write appears the cycle after the word that completes it; core_init
// rises the cycle after the final write. Backpressure: load_ready is held for the whole
// load, so flushes never insert bubbles; each dump beat is held until dump_ready.
// Ports:
//   clk, rst                    clock, async active-high reset
//   start                       begin load/run/dump (honoured only in IDLE/DONE)
//   load_base_addr              byte address of the first program word
//   load_valid/ready/word/last  program word stream
//   mem_wr_*                    one-cycle block write (addr, data lanes, word mask)
//   core_init                   core initialisation pulse
//   core_pc                     core fetch PC, watched for HALT_PC during RUN
//   arf_in                      flattened ARF, captured when RUN ends
//   dump_valid/ready/idx/data   register dump stream, index order 0..N_REGS-1
//   done, timed_out, load_oob   status flags, cleared by start
//   cycle_count                 saturating RUN cycle count
module run_ctrl #(
  parameter int          WORD_WIDTH      = 32,
  parameter int          WORDS_PER_BLOCK = 4,
  parameter int          N_BLOCKS        = 64,
  parameter int          N_REGS          = 32,
  parameter logic [31:0] HALT_PC         = 32'h0,
  parameter int          TIMEOUT         = 1000,
  parameter int          INIT_CYCLES     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [31:0]                           load_base_addr,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  input  logic [WORD_WIDTH-1:0]                 load_word,
  input  logic                                  load_last,
  output logic                                  mem_wr_en,
  output logic [$clog2(N_BLOCKS)-1:0]           mem_wr_block_addr,
  output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_wr_data,
  output logic [WORDS_PER_BLOCK-1:0]            mem_wr_wmask,
  output logic                                  core_init,
  input  logic [31:0]                           core_pc,
  input  logic [N_REGS*WORD_WIDTH-1:0]          arf_in,
  output logic                                  dump_valid,
  input  logic                                  dump_ready,
  output logic [$clog2(N_REGS)-1:0]             dump_idx,
  output logic [WORD_WIDTH-1:0]                 dump_data,
  output logic                                  done,
  output logic                                  timed_out,
  output logic                                  load_oob,
  output logic [31:0]                           cycle_count
);

  localparam int LANE_W = $clog2(WORDS_PER_BLOCK);
  localparam int BLK_W  = $clog2(N_BLOCKS);
  localparam int IDX_W  = $clog2(N_REGS);
  localparam int PTR_W  = 30;
  localparam int BIDX_W = PTR_W - LANE_W;
  localparam int BUF_W  = WORD_WIDTH * WORDS_PER_BLOCK;

  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(WORDS_PER_BLOCK - 1);
  localparam logic [BIDX_W-1:0] BIDX_LIMIT = BIDX_W'(N_BLOCKS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_REGS - 1);
  localparam logic [31:0]       INIT_LEN   = 32'(INIT_CYCLES);
  localparam logic [31:0]       TIMEOUT_C  = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PTR_W-1:0]           r_ptr;
  logic [BUF_W-1:0]           r_buf;
  logic [WORDS_PER_BLOCK-1:0] r_mask;
  logic                       r_wr_en;
  logic [BLK_W-1:0]           r_wr_addr;
  logic [BUF_W-1:0]           r_wr_data;
  logic [WORDS_PER_BLOCK-1:0] r_wr_mask;
  logic [31:0]                r_init_cnt;
  logic [31:0]                r_cycle_cnt;
  logic                       r_timed_out;
  logic                       r_load_oob;
  logic [N_REGS*WORD_WIDTH-1:0] r_arf;
  logic [IDX_W-1:0]           r_dump_idx;

  logic                       w_start_ok;
  logic                       w_accept;
  logic [LANE_W-1:0]          w_lane;
  logic [BIDX_W-1:0]          w_bidx;
  logic                       w_oob;
  logic                       w_flush;
  logic [BUF_W-1:0]           w_buf_nxt;
  logic [WORDS_PER_BLOCK-1:0] w_mask_nxt;
  logic [31:0]                w_cnt_inc;
  logic                       w_halt;
  logic                       w_timeout;
  logic                       w_dump_hs;
  logic [WORD_WIDTH-1:0]      w_dump_word;
  logic                       w_unused;

  // Byte-offset bits of the base address carry no information (word aligned).
  assign w_unused = &{1'b0, load_base_addr[1:0]};

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_accept   = load_valid && (r_state == ST_LOAD);
  assign w_lane     = r_ptr[LANE_W-1:0];
  assign w_bidx     = r_ptr[PTR_W-1:LANE_W];
  // Addresses beyond the last block are dropped rather than wrapped.
  assign w_oob      = (w_bidx >= BIDX_LIMIT);
  assign w_flush    = w_accept && !w_oob && (w_lane == LANE_LAST || load_last);
  assign w_cnt_inc  = (r_cycle_cnt == 32'hFFFF_FFFF) ? r_cycle_cnt : r_cycle_cnt + 32'd1;
  assign w_halt     = (core_pc == HALT_PC);
  // Timeout fires on the run cycle whose increment reaches TIMEOUT.
  assign w_timeout  = (w_cnt_inc >= TIMEOUT_C);
  assign w_dump_hs  = dump_ready && (r_state == ST_DUMP);

  // Block buffer with the incoming word merged in; used both to update the
  // buffer and as the flush payload so the completing word lands in the write.
  always_comb begin
    w_buf_nxt  = r_buf;
    w_mask_nxt = r_mask;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      if (w_lane == LANE_W'(i)) begin
        w_buf_nxt[i*WORD_WIDTH +: WORD_WIDTH] = load_word;
        w_mask_nxt[i]                         = 1'b1;
      end
    end
  end

  always_comb begin
    w_dump_word = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (r_dump_idx == IDX_W'(i)) begin
        w_dump_word = r_arf[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    core_init   = 1'b0;
    dump_valid  = 1'b0;
    dump_data   = '0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (w_accept && load_last) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        // Count 0 is the cycle carrying the final flush write; the pulse follows it.
        core_init = (r_init_cnt != 32'd0);
        if (r_init_cnt == INIT_LEN) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt || w_timeout) w_state_nxt = ST_DUMP;
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_data  = w_dump_word;
        if (w_dump_hs && r_dump_idx == IDX_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_start_ok) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_buf       <= '0;
      r_mask      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_mask   <= '0;
      r_init_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_timed_out <= 1'b0;
      r_load_oob  <= 1'b0;
      r_arf       <= '0;
      r_dump_idx  <= '0;
    end else begin
      r_wr_en <= 1'b0;

      if (w_start_ok) begin
        r_ptr       <= load_base_addr[31:2];
        r_buf       <= '0;
        r_mask      <= '0;
        r_cycle_cnt <= '0;
        r_timed_out <= 1'b0;
        r_load_oob  <= 1'b0;
      end

      if (w_accept) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (w_oob) begin
          r_load_oob <= 1'b1;
        end else if (w_flush) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_bidx[BLK_W-1:0];
          r_wr_data <= w_buf_nxt;
          r_wr_mask <= w_mask_nxt;
          r_buf     <= '0;
          r_mask    <= '0;
        end else begin
          r_buf  <= w_buf_nxt;
          r_mask <= w_mask_nxt;
        end
      end

      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 32'd1;
      end else begin
        r_init_cnt <= '0;
      end

      if (r_state == ST_RUN) begin
        r_cycle_cnt <= w_cnt_inc;
        if (w_halt || w_timeout) begin
          // A halt in the same cycle as the timeout is reported as a halt.
          r_timed_out <= !w_halt;
          r_arf       <= arf_in;
          r_dump_idx  <= '0;
        end
      end

      if (w_dump_hs && r_dump_idx != IDX_LAST) begin
        r_dump_idx <= r_dump_idx + IDX_W'(1);
      end
    end
  end

  assign mem_wr_en         = r_wr_en;
  assign mem_wr_block_addr = r_wr_addr;
  assign mem_wr_data       = r_wr_data;
  assign mem_wr_wmask      = r_wr_mask;
  assign dump_idx          = r_dump_idx;
  assign timed_out         = r_timed_out;
  assign load_oob          = r_load_oob;
  assign cycle_count       = r_cycle_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int WW = 32;
  localparam int NR = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      load_base_addr = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [31:0]      load_word = '0;
  logic             load_last = 1'b0;
  logic             mem_wr_en;
  logic [5:0]       mem_wr_block_addr;
  logic [127:0]     mem_wr_data;
  logic [3:0]       mem_wr_wmask;
  logic             core_init;
  logic [31:0]      core_pc = 32'h40;
  logic [NR*WW-1:0] arf_in = '0;
  logic             dump_valid;
  logic             dump_ready = 1'b0;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             done;
  logic             timed_out;
  logic             load_oob;
  logic [31:0]      cycle_count;

  run_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .load_base_addr    (load_base_addr),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_word         (load_word),
    .load_last         (load_last),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_block_addr (mem_wr_block_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_wmask      (mem_wr_wmask),
    .core_init         (core_init),
    .core_pc           (core_pc),
    .arf_in            (arf_in),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_idx          (dump_idx),
    .dump_data         (dump_data),
    .done              (done),
    .timed_out         (timed_out),
    .load_oob          (load_oob),
    .cycle_count       (cycle_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Expected block writes for the 14-word program at base 0x18c.
  localparam logic [5:0]   P23_BLK [5] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h1c};
  localparam logic [3:0]   P23_MSK [5] = '{4'b1000, 4'b1111, 4'b1111, 4'b1111, 4'b0001};
  localparam logic [127:0] P23_DAT [5] = '{
    {32'h100, 96'h0},
    {32'h104, 32'h103, 32'h102, 32'h101},
    {32'h108, 32'h107, 32'h106, 32'h105},
    {32'h10C, 32'h10B, 32'h10A, 32'h109},
    {96'h0, 32'h10D}
  };
  localparam int P23_OFS [5] = '{0, 4, 8, 12, 13};

  logic [5:0]   wq_addr[$];
  logic [3:0]   wq_mask[$];
  logic [127:0] wq_data[$];
  int           wq_cyc[$];
  int           iq_cyc[$];
  logic [31:0]  arf_model[NR];

  always @(posedge clk) cyc <= cyc + 1;

  // Append-only logs of block writes and core_init cycles.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wq_addr.push_back(mem_wr_block_addr);
      wq_mask.push_back(mem_wr_wmask);
      wq_data.push_back(mem_wr_data);
      wq_cyc.push_back(cyc);
    end
    if (core_init === 1'b1) iq_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_wr_addr"}, mem_wr_block_addr, 0);
    chk({tag, "_wr_data"}, mem_wr_data, 0);
    chk({tag, "_wr_mask"}, mem_wr_wmask, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_idx"}, dump_idx, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_load_oob"}, load_oob, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic set_arf(input logic [31:0] seed);
    for (int i = 0; i < NR; i++) begin
      arf_model[i] = seed ^ (32'h9E37_79B9 * (i + 1));
      arf_in[i*WW +: WW] = arf_model[i];
    end
  endtask

  // Returns at the negedge of the cycle that carries the final flush write.
  task automatic send_prog(input logic [31:0] base, input int n, input logic [31:0] w0);
    @(negedge clk);
    start = 1'b1;
    load_base_addr = base;
    @(negedge clk);
    start = 1'b0;
    chk("start_clr_done", done, 0);
    chk("start_clr_timed_out", timed_out, 0);
    chk("start_clr_oob", load_oob, 0);
    chk("start_clr_count", cycle_count, 0);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_word  = w0 + i;
      load_last  = (i == n - 1);
      chk($sformatf("load_ready_w%0d", i), load_ready, 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_word  = '0;
    chk("load_ready_after_last", load_ready, 0);
  endtask

  task automatic wait_init();
    int t;
    t = 0;
    while (core_init !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("core_init_seen", core_init, 1);
  endtask

  task automatic check_prog23(input string tag, input int wb, input int ib);
    int n;
    n = wq_addr.size() - wb;
    chk({tag, "_n_writes"}, n, 5);
    for (int k = 0; k < 5 && k < n; k++) begin
      chk($sformatf("%s_blk%0d", tag, k), wq_addr[wb+k], P23_BLK[k]);
      chk($sformatf("%s_mask%0d", tag, k), wq_mask[wb+k], P23_MSK[k]);
      chk($sformatf("%s_data%0d", tag, k), wq_data[wb+k], P23_DAT[k]);
      chk($sformatf("%s_ofs%0d", tag, k), wq_cyc[wb+k] - wq_cyc[wb], P23_OFS[k]);
    end
    chk({tag, "_init_cycles"}, iq_cyc.size() - ib, 1);
    if (iq_cyc.size() > ib && n > 0)
      chk({tag, "_init_after_wr"}, iq_cyc[ib] - wq_cyc[wb+n-1], 1);
  endtask

  // dump_ready is high on one cycle out of every 'period'.
  task automatic run_dump(input int period);
    int k;
    int j;
    k = 0;
    j = 0;
    while (k < NR && j < 400) begin
      dump_ready = (j % period == 0);
      if (dump_valid === 1'b1) begin
        chk($sformatf("dump_idx_%0d", k), dump_idx, k);
        chk($sformatf("dump_data_%0d", k), dump_data, arf_model[k]);
        if (dump_ready) k++;
      end
      @(negedge clk);
      j++;
    end
    dump_ready = 1'b0;
    chk("dump_beats", k, NR);
    chk("dump_done", done, 1);
    chk("dump_valid_after", dump_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int ib;

    #1 rst = 1'b1;
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_load_ready", load_ready, 0);

    // Unaligned-start program, halt after 37 busy cycles, dump with ready held.
    set_arf(32'hC0DE_0000);
    core_pc = 32'h0001_018c;
    wb = wq_addr.size();
    ib = iq_cyc.size();
    send_prog(32'h18c, 14, 32'h100);
    wait_init();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_in_run", load_ready, 0);
    repeat (16) @(negedge clk);
    chk("run_count_36", cycle_count, 36);
    @(negedge clk);
    chk("run_count_37", cycle_count, 37);
    chk("no_early_dump", dump_valid, 0);
    core_pc = 32'h0;
    @(negedge clk);
    chk("halt_dump_valid", dump_valid, 1);
    chk("halt_count", cycle_count, 38);
    chk("halt_timed_out", timed_out, 0);
    chk("dump_ready_low_load", load_ready, 0);
    arf_in  = ~arf_in;
    core_pc = 32'h0001_018c;
    check_prog23("p23", wb, ib);
    run_dump(1);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);
    chk("count_held", cycle_count, 38);

    // Timeout with no halt, dump_ready on one cycle in three.
    set_arf(32'h5A5A_0001);
    core_pc = 32'h40;
    wb = wq_addr.size();
    send_prog(32'h0, 3, 32'h200);
    wait_init();
    chk("short_n_writes", wq_addr.size() - wb, 1);
    if (wq_addr.size() > wb) begin
      chk("short_blk", wq_addr[wb], 0);
      chk("short_mask", wq_mask[wb], 4'b0111);
      chk("short_data", wq_data[wb], {32'h0, 32'h202, 32'h201, 32'h200});
    end
    repeat (1000) @(negedge clk);
    chk("to_count_999", cycle_count, 999);
    chk("to_not_yet", dump_valid, 0);
    @(negedge clk);
    chk("to_dump_valid", dump_valid, 1);
    chk("to_count", cycle_count, 1000);
    chk("to_timed_out", timed_out, 1);
    arf_in = ~arf_in;
    run_dump(3);

    // Halt and timeout in the same cycle: halt wins.
    set_arf(32'h1234_8765);
    core_pc = 32'h40;
    send_prog(32'h0, 1, 32'h300);
    wait_init();
    repeat (1000) @(negedge clk);
    core_pc = 32'h0;
    @(negedge clk);
    chk("tie_dump_valid", dump_valid, 1);
    chk("tie_count", cycle_count, 1000);
    chk("tie_timed_out", timed_out, 0);
    core_pc = 32'h40;
    run_dump(1);

    // Load crossing the top of memory; pc already at HALT_PC before RUN.
    set_arf(32'hBEEF_0000);
    core_pc = 32'h0;
    wb = wq_addr.size();
    send_prog(32'h3FC, 2, 32'hAAA0);
    chk("oob_flag", load_oob, 1);
    wait_init();
    chk("oob_no_halt_in_init", dump_valid, 0);
    @(negedge clk);
    chk("oob_run_first", dump_valid, 0);
    @(negedge clk);
    chk("oob_halt_dump", dump_valid, 1);
    chk("oob_count", cycle_count, 1);
    chk("oob_flag_kept", load_oob, 1);
    chk("oob_n_writes", wq_addr.size() - wb, 1);
    if (wq_addr.size() > wb) begin
      chk("oob_blk", wq_addr[wb], 6'h3F);
      chk("oob_mask", wq_mask[wb], 4'b1000);
      chk("oob_data", wq_data[wb], {32'hAAA0, 96'h0});
    end
    core_pc = 32'h40;
    run_dump(1);

    // Reset in the middle of RUN, then the first program again.
    core_pc = 32'h0001_018c;
    send_prog(32'h18c, 14, 32'h100);
    wait_init();
    repeat (10) @(negedge clk);
    chk("pre_reset_count", cycle_count, 9);
    rst = 1'b1;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    wb = wq_addr.size();
    ib = iq_cyc.size();
    send_prog(32'h18c, 14, 32'h100);
    wait_init();
    repeat (3) @(negedge clk);
    check_prog23("p23_again", wb, ib);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
